// File: rtl/parity_job_scheduler_pkg.sv
// Shared types and constants for the parity job scheduler and its serial parity engine.
package parity_job_scheduler_pkg;

    localparam int WORD_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } sched_state_t;

    typedef enum logic {
        EVEN = 1'b0,
        ODD  = 1'b1
    } parity_state_t;

endpackage

// File: rtl/parity_job_scheduler_engine.sv
// Serial parity engine: tracks running parity of a bit stream, LSB first,
// and reports the odd-parity bit (1 when the ones count so far is even).
module serial_odd_parity_engine
    import parity_job_scheduler_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic bit_valid,
    input  logic bit_in,
    output logic parity_out
);

    parity_state_t par_q, par_d;

    always_comb begin
        par_d = par_q;
        if (clear) begin
            par_d = EVEN;
        end else if (bit_valid && bit_in) begin
            par_d = (par_q == EVEN) ? ODD : EVEN;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_q <= EVEN;
        end else begin
            par_q <= par_d;
        end
    end

    assign parity_out = (par_q == EVEN);

endmodule

// File: rtl/parity_job_scheduler.sv
// Round-robin job scheduler: grants one requester, streams its 3-bit word through
// a serial parity engine and returns word, id and odd parity. Optional job counter
// output jobs_done is enabled by defining PARITY_SCHED_JOB_COUNT_EN.
module parity_job_scheduler
    import parity_job_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [WORD_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic                      resp_parity,
    output logic [ID_W-1:0]           resp_id,
    output logic [WORD_W-1:0]         resp_data,
    output logic                      busy
`ifdef PARITY_SCHED_JOB_COUNT_EN
    ,
    output logic [7:0]                jobs_done
`endif
);

    localparam int CNT_W = $clog2(WORD_W);

    sched_state_t        state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                eng_clear;
    logic                eng_bit_valid;
    logic                eng_bit_in;
    logic                eng_parity;

    logic [WORD_W-1:0]   req_word [NUM_REQ];
    logic [NUM_REQ-1:0]  at_or_above;
    logic [NUM_REQ-1:0]  upper_valid;
    logic [NUM_REQ-1:0]  grant_oh;
    logic [ID_W-1:0]     enc_chain [NUM_REQ+1];
    logic [ID_W-1:0]     grant_idx;

    // Split the flat request bus and build the "index >= rr_ptr" mask.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_word[gi]    = req_data[WORD_W*gi +: WORD_W];
            assign at_or_above[gi] = (ID_W'(gi) >= rr_ptr_q);
        end
    endgenerate

    // Lowest valid index at or above rr_ptr wins; otherwise wrap to lowest valid overall.
    assign upper_valid = req_valid & at_or_above;
    assign grant_oh    = (|upper_valid) ? (upper_valid & (~upper_valid + NUM_REQ'(1)))
                                        : (req_valid & (~req_valid + NUM_REQ'(1)));

    assign enc_chain[0] = '0;
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_enc
            assign enc_chain[gi+1] = enc_chain[gi] | (grant_oh[gi] ? ID_W'(gi) : '0);
        end
    endgenerate
    assign grant_idx = enc_chain[NUM_REQ];

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        id_d          = id_q;
        word_d        = word_q;
        cnt_d         = cnt_q;
        eng_clear     = 1'b0;
        eng_bit_valid = 1'b0;
        req_ready     = '0;
        case (state_q)
            IDLE: begin
                if (|req_valid && !reset) begin
                    req_ready = grant_oh;
                    eng_clear = 1'b1;
                    word_d    = req_word[grant_idx];
                    id_d      = grant_idx;
                    rr_ptr_d  = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
                    cnt_d     = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                eng_bit_valid = 1'b1;
                cnt_d         = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WORD_W - 1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            word_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            word_q   <= word_d;
            cnt_q    <= cnt_d;
        end
    end

    assign eng_bit_in = word_q[cnt_q];

    serial_odd_parity_engine u_engine (
        .clk        (clk),
        .reset      (reset),
        .clear      (eng_clear),
        .bit_valid  (eng_bit_valid),
        .bit_in     (eng_bit_in),
        .parity_out (eng_parity)
    );

    // Result fields read as zero outside RESP so reset and idle look identical.
    assign resp_valid  = (state_q == RESP);
    assign resp_parity = resp_valid & eng_parity;
    assign resp_id     = resp_valid ? id_q : '0;
    assign resp_data   = resp_valid ? word_q : '0;
    assign busy        = (state_q != IDLE);

`ifdef PARITY_SCHED_JOB_COUNT_EN
    logic [7:0] jobs_q, jobs_d;

    always_comb begin
        jobs_d = jobs_q;
        if (resp_valid && resp_ready && (jobs_q != 8'hFF)) begin
            jobs_d = jobs_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            jobs_q <= '0;
        end else begin
            jobs_q <= jobs_d;
        end
    end

    assign jobs_done = jobs_q;
`endif

endmodule

// File: tb/tb_parity_job_scheduler.sv
// Directed self-checking bench for parity_job_scheduler (counter checks when
// PARITY_SCHED_JOB_COUNT_EN is defined).
module tb_parity_job_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [11:0] req_data = '0;
    logic        resp_ready = 1'b0;
    logic [3:0]  req_ready;
    logic        resp_valid;
    logic        resp_parity;
    logic [1:0]  resp_id;
    logic [2:0]  resp_data;
    logic        busy;
`ifdef PARITY_SCHED_JOB_COUNT_EN
    logic [7:0]  jobs_done;
`endif

    int tests = 0;
    int fails = 0;

    parity_job_scheduler #(.NUM_REQ(4), .ID_W(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_parity (resp_parity),
        .resp_id     (resp_id),
        .resp_data   (resp_data),
        .busy        (busy)
`ifdef PARITY_SCHED_JOB_COUNT_EN
        ,
        .jobs_done   (jobs_done)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"},   32'(req_ready),   32'd0);
        check({tag, "_resp_valid"},  32'(resp_valid),  32'd0);
        check({tag, "_resp_parity"}, 32'(resp_parity), 32'd0);
        check({tag, "_resp_id"},     32'(resp_id),     32'd0);
        check({tag, "_resp_data"},   32'(resp_data),   32'd0);
        check({tag, "_busy"},        32'(busy),        32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One job from a single requester; resp_valid expected after four edges.
    task automatic run_job(input int id, input logic [2:0] w, input logic exp_par);
        @(negedge clk);
        req_data = '0;
        req_data[3*id +: 3] = w;
        req_valid = 4'(1 << id);
        resp_ready = 1'b0;
        #1;
        check("grant", 32'(req_ready), 32'(1 << id));
        @(negedge clk);
        req_valid = '0;
        check("shift_req_ready", 32'(req_ready), 32'd0);
        check("shift_busy", 32'(busy), 32'd1);
        repeat (2) begin
            @(negedge clk);
            check("no_resp_yet", 32'(resp_valid), 32'd0);
        end
        @(negedge clk);
        check("resp_valid", 32'(resp_valid), 32'd1);
        check("resp_parity", 32'(resp_parity), 32'(exp_par));
        check("resp_id", 32'(resp_id), 32'(id));
        check("resp_data", 32'(resp_data), 32'(w));
        resp_ready = 1'b1;
        @(negedge clk);
        check("after_hs_valid", 32'(resp_valid), 32'd0);
        check("after_hs_busy", 32'(busy), 32'd0);
        resp_ready = 1'b0;
    endtask

    logic [7:0] par_tab;
    logic [2:0] rr_word [4];
    logic       rr_par  [4];
    logic [2:0] w;

    initial begin
        par_tab = 8'b0110_1001;
        rr_word = '{3'b001, 3'b110, 3'b011, 3'b111};
        rr_par  = '{1'b0, 1'b1, 1'b1, 1'b0};

        #2 reset = 1'b1;
        #1 check_all_zero("por");
        @(negedge clk);
        reset = 1'b0;

        // Single job, word 000 from requester 0
        run_job(0, 3'b000, 1'b1);

        // Every word from requester 2
        for (int i = 0; i < 8; i++) begin
            w = 3'(i);
            run_job(2, w, par_tab[i]);
        end

        // Round-robin with all requesters held valid
        do_reset();
        req_data = {3'b111, 3'b011, 3'b110, 3'b001};
        req_valid = 4'hF;
        resp_ready = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            check("rr_grant", 32'(req_ready), 32'(1 << (k % 4)));
            repeat (4) @(negedge clk);
            check("rr_valid", 32'(resp_valid), 32'd1);
            check("rr_id", 32'(resp_id), 32'(k % 4));
            check("rr_data", 32'(resp_data), 32'(rr_word[k % 4]));
            check("rr_parity", 32'(resp_parity), 32'(rr_par[k % 4]));
            @(negedge clk);
        end
        req_valid = '0;
        resp_ready = 1'b0;

        // Backpressure: hold result for 10 cycles while other requests wait
        @(negedge clk);
        req_data = '0;
        req_data[9 +: 3] = 3'b101;
        req_valid = 4'b1000;
        #1;
        check("bp_grant", 32'(req_ready), 32'b1000);
        @(negedge clk);
        req_valid = 4'hF;
        repeat (3) @(negedge clk);
        check("bp_valid", 32'(resp_valid), 32'd1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(resp_valid), 32'd1);
            check("bp_hold_data", 32'(resp_data), 32'b101);
            check("bp_hold_id", 32'(resp_id), 32'd3);
            check("bp_hold_parity", 32'(resp_parity), 32'd1);
            check("bp_hold_req_ready", 32'(req_ready), 32'd0);
        end
        req_valid = '0;
        resp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 32'(resp_valid), 32'd0);
        check("bp_release_busy", 32'(busy), 32'd0);
        resp_ready = 1'b0;

        // Reset on the second shift cycle abandons the job
        @(negedge clk);
        req_data = '0;
        req_data[6 +: 3] = 3'b011;
        req_valid = 4'b0100;
        #1;
        check("mid_grant", 32'(req_ready), 32'b0100);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("mid_no_resp", 32'(resp_valid), 32'd0);
            check("mid_idle", 32'(busy), 32'd0);
        end
        req_valid = 4'hF;
        #1;
        check("post_reset_grant", 32'(req_ready), 32'b0001);
        @(negedge clk);
        req_valid = '0;

`ifdef PARITY_SCHED_JOB_COUNT_EN
        do_reset();
        check("jobs_after_reset", 32'(jobs_done), 32'd0);
        req_valid = 4'b0001;
        resp_ready = 1'b1;
        repeat (50) @(negedge clk);
        check("jobs_10", 32'(jobs_done), 32'd10);
        repeat (1450) @(negedge clk);
        check("jobs_sat", 32'(jobs_done), 32'd255);
        req_valid = '0;
        reset = 1'b1;
        #1;
        check("jobs_reset", 32'(jobs_done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        resp_ready = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
